// File: rtl/des_entry_ctrl.sv
// Key/data entry and cipher sequencing controller for the board-level DES flow.
// Optional feature macro DES_ENTRY_CHAIN_EN: go in RESULT re-runs the core on the result.
module des_entry_ctrl #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned WORDS = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IN_W-1:0]         user_input,
  input  logic                    send_n,
  input  logic                    back_n,
  input  logic                    go_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        select_disp,
  output logic                    core_start,
  output logic                    core_decrypt,
  output logic [IN_W*WORDS-1:0]   core_key,
  output logic [IN_W*WORDS-1:0]   core_data,
  input  logic                    core_done,
  input  logic [IN_W*WORDS-1:0]   core_result,
  output logic [IN_W-1:0]         disp,
  output logic [2:0]              phase,
  output logic [SEL_W-1:0]        word_idx,
  output logic                    busy
);

  localparam int unsigned BW = IN_W * WORDS;
  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(WORDS - 1);

  typedef enum logic [2:0] {
    StKeyEntry  = 3'd0,
    StKeyShow   = 3'd1,
    StDataEntry = 3'd2,
    StDataShow  = 3'd3,
    StRun       = 3'd4,
    StWaitCore  = 3'd5,
    StResult    = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [BW-1:0]     key_q, key_d;
  logic [BW-1:0]     data_q, data_d;
  logic [BW-1:0]     result_q, result_d;
  logic              decrypt_q, decrypt_d;
  logic [IN_W-1:0]   disp_q, disp_d;
  logic              send_prev_q, back_prev_q, go_prev_q;
  logic              send_press_q, back_press_q, go_press_q;
  logic              do_send, do_back, do_go;

  // Selectors outside 0..WORDS-1 fall through to zero.
  function automatic logic [IN_W-1:0] chunk_of(input logic [BW-1:0] blk,
                                               input logic [SEL_W-1:0] sel);
    logic [IN_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (sel == SEL_W'(i)) r = blk[i*IN_W +: IN_W];
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] put_chunk(input logic [BW-1:0] blk,
                                              input logic [SEL_W-1:0] sel,
                                              input logic [IN_W-1:0] val);
    logic [BW-1:0] r;
    r = blk;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (sel == SEL_W'(i)) r[i*IN_W +: IN_W] = val;
    end
    return r;
  endfunction

  // One action per press; send beats back beats go.
  assign do_send = send_press_q;
  assign do_back = back_press_q & ~send_press_q;
  assign do_go   = go_press_q & ~send_press_q & ~back_press_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      send_prev_q  <= 1'b1;
      back_prev_q  <= 1'b1;
      go_prev_q    <= 1'b1;
      send_press_q <= 1'b0;
      back_press_q <= 1'b0;
      go_press_q   <= 1'b0;
    end else begin
      send_prev_q  <= send_n;
      back_prev_q  <= back_n;
      go_prev_q    <= go_n;
      send_press_q <= send_prev_q & ~send_n;
      back_press_q <= back_prev_q & ~back_n;
      go_press_q   <= go_prev_q & ~go_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StKeyEntry;
      idx_q     <= '0;
      key_q     <= '0;
      data_q    <= '0;
      result_q  <= '0;
      decrypt_q <= 1'b0;
      disp_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      key_q     <= key_d;
      data_q    <= data_d;
      result_q  <= result_d;
      decrypt_q <= decrypt_d;
      disp_q    <= disp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    key_d     = key_q;
    data_d    = data_q;
    result_d  = result_q;
    decrypt_d = decrypt_q;
    disp_d    = '0;
    case (state_q)
      StKeyEntry: begin
        disp_d = user_input;
        if (do_send) begin
          key_d = put_chunk(key_q, idx_q, user_input);
          if (idx_q == LastIdx) begin
            state_d = StKeyShow;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + SEL_W'(1);
          end
        end else if (do_back && idx_q != '0) begin
          idx_d = idx_q - SEL_W'(1);
        end
      end
      StKeyShow: begin
        disp_d = chunk_of(key_q, select_disp);
        if (do_send) begin
          state_d = StDataEntry;
          idx_d   = '0;
        end else if (do_back) begin
          state_d = StKeyEntry;
          idx_d   = LastIdx;
        end
      end
      StDataEntry: begin
        disp_d = user_input;
        if (do_send) begin
          data_d = put_chunk(data_q, idx_q, user_input);
          if (idx_q == LastIdx) begin
            state_d = StDataShow;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + SEL_W'(1);
          end
        end else if (do_back) begin
          if (idx_q != '0) idx_d = idx_q - SEL_W'(1);
          else             state_d = StKeyShow;
        end
      end
      StDataShow: begin
        disp_d = chunk_of(data_q, select_disp);
        if (do_back) begin
          state_d = StDataEntry;
          idx_d   = LastIdx;
        end else if (do_go) begin
          // Mode latched on the launch edge so it is valid alongside core_start.
          state_d   = StRun;
          decrypt_d = mode;
        end
      end
      StRun: begin
        state_d = StWaitCore;
      end
      StWaitCore: begin
        if (core_done) begin
          result_d = core_result;
          state_d  = StResult;
        end
      end
      StResult: begin
        disp_d = chunk_of(result_q, select_disp);
        if (do_send) begin
          state_d = StDataEntry;
          idx_d   = '0;
        end else if (do_back) begin
          state_d = StKeyEntry;
          idx_d   = '0;
        end else if (do_go) begin
`ifdef DES_ENTRY_CHAIN_EN
          data_d    = result_q;
          decrypt_d = ~decrypt_q;
          state_d   = StRun;
`else
          state_d   = state_q;
`endif
        end
      end
      default: begin
        state_d = StKeyEntry;
        idx_d   = '0;
      end
    endcase
  end

  assign core_start   = (state_q == StRun);
  assign busy         = (state_q == StRun) || (state_q == StWaitCore);
  assign core_decrypt = decrypt_q;
  assign core_key     = key_q;
  assign core_data    = data_q;
  assign disp         = disp_q;
  assign phase        = state_q;
  assign word_idx     = idx_q;

endmodule

// File: tb/tb_des_entry_ctrl.sv
// Randomized self-checking bench for des_entry_ctrl against a transaction-level model.
// Follows DES_ENTRY_CHAIN_EN when defined.
module tb_des_entry_ctrl;

  localparam int IN_W  = 16;
  localparam int WORDS = 4;
  localparam int SEL_W = 2;
  localparam int BW    = IN_W * WORDS;

`ifdef DES_ENTRY_CHAIN_EN
  localparam bit Chain = 1'b1;
`else
  localparam bit Chain = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [IN_W-1:0]  user_input = '0;
  logic             send_n = 1'b1;
  logic             back_n = 1'b1;
  logic             go_n = 1'b1;
  logic             mode = 1'b0;
  logic [SEL_W-1:0] select_disp = '0;
  logic             core_start;
  logic             core_decrypt;
  logic [BW-1:0]    core_key;
  logic [BW-1:0]    core_data;
  logic             core_done = 1'b0;
  logic [BW-1:0]    core_result = '0;
  logic [IN_W-1:0]  disp;
  logic [2:0]       phase;
  logic [SEL_W-1:0] word_idx;
  logic             busy;

  des_entry_ctrl #(.IN_W(IN_W), .WORDS(WORDS), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .user_input(user_input), .send_n(send_n), .back_n(back_n),
    .go_n(go_n), .mode(mode), .select_disp(select_disp), .core_start(core_start),
    .core_decrypt(core_decrypt), .core_key(core_key), .core_data(core_data),
    .core_done(core_done), .core_result(core_result), .disp(disp), .phase(phase),
    .word_idx(word_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: phase number, entry index, chunk arrays, result block, latched direction.
  int              m_phase;
  int              m_idx;
  logic [IN_W-1:0] m_key[WORDS];
  logic [IN_W-1:0] m_data[WORDS];
  logic [BW-1:0]   m_result;
  logic            m_dec;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_idx = 0;
    m_result = '0;
    m_dec = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      m_key[i] = '0;
      m_data[i] = '0;
    end
  endtask

  function automatic logic [BW-1:0] key_blk();
    logic [BW-1:0] r;
    for (int i = 0; i < WORDS; i++) r[i*IN_W +: IN_W] = m_key[i];
    return r;
  endfunction

  function automatic logic [BW-1:0] data_blk();
    logic [BW-1:0] r;
    for (int i = 0; i < WORDS; i++) r[i*IN_W +: IN_W] = m_data[i];
    return r;
  endfunction

  function automatic logic [IN_W-1:0] model_disp();
    case (m_phase)
      0, 2:    return user_input;
      1:       return m_key[select_disp];
      3:       return m_data[select_disp];
      6:       return m_result[int'(select_disp)*IN_W +: IN_W];
      default: return '0;
    endcase
  endfunction

  task automatic model_send();
    case (m_phase)
      0, 2: begin
        if (m_phase == 0) m_key[m_idx] = user_input;
        else              m_data[m_idx] = user_input;
        if (m_idx == WORDS - 1) begin
          m_phase = m_phase + 1;
          m_idx = 0;
        end else begin
          m_idx++;
        end
      end
      1, 6: begin
        m_phase = 2;
        m_idx = 0;
      end
      default: ;
    endcase
  endtask

  task automatic model_back();
    case (m_phase)
      0: if (m_idx > 0) m_idx--;
      1: begin m_phase = 0; m_idx = WORDS - 1; end
      2: if (m_idx > 0) m_idx--; else m_phase = 1;
      3: begin m_phase = 2; m_idx = WORDS - 1; end
      6: begin m_phase = 0; m_idx = 0; end
      default: ;
    endcase
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check_eq({tag, "_phase"}, 64'(phase), 64'(m_phase));
    check_eq({tag, "_idx"}, 64'(word_idx), 64'(m_idx));
    check_eq({tag, "_key"}, core_key, key_blk());
    check_eq({tag, "_data"}, core_data, data_blk());
    check_eq({tag, "_disp"}, 64'(disp), 64'(model_disp()));
    check_eq({tag, "_busy"}, 64'(busy), 64'(0));
    check_eq({tag, "_start"}, 64'(core_start), 64'(0));
  endtask

  // Non-launching press; the model applies the single winning action.
  task automatic press(input bit s, input bit b, input bit g, input int hold, input string tag);
    @(posedge clk); #1;
    send_n = ~s;
    back_n = ~b;
    go_n = ~g;
    repeat (hold) @(posedge clk);
    #1;
    send_n = 1'b1;
    back_n = 1'b1;
    go_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (s) model_send();
    else if (b) model_back();
    check_idle(tag);
  endtask

  // Launch via go, act as the cipher core, optionally reset while it is busy.
  task automatic do_run(input int dly, input bit abort, input string tag);
    bit seen;
    bit early;
    logic [BW-1:0] r;
    mode = 1'($urandom);
    if (m_phase == 6) begin
      for (int i = 0; i < WORDS; i++) m_data[i] = m_result[i*IN_W +: IN_W];
      m_dec = ~m_dec;
    end else begin
      m_dec = mode;
    end
    early = 1'($urandom);
    @(posedge clk); #1;
    go_n = 1'b0;
    core_done = early;
    @(posedge clk); #1;
    go_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (core_start) seen = 1'b1;
    end
    check_eq({tag, "_start_seen"}, 64'(seen), 64'(1));
    if (!seen) begin
      core_done = 1'b0;
      return;
    end
    check_eq({tag, "_run_phase"}, 64'(phase), 64'(4));
    check_eq({tag, "_run_busy"}, 64'(busy), 64'(1));
    check_eq({tag, "_decrypt"}, 64'(core_decrypt), 64'(m_dec));
    check_eq({tag, "_run_key"}, core_key, key_blk());
    check_eq({tag, "_run_data"}, core_data, data_blk());
    // A done held through RUN must not short-cut WAIT_CORE.
    @(posedge clk); #1;
    core_done = 1'b0;
    @(negedge clk);
    check_eq({tag, "_start_width"}, 64'(core_start), 64'(0));
    check_eq({tag, "_wait_phase"}, 64'(phase), 64'(5));
    if (abort) begin
      bit restarted;
      #1 rst = 1'b0;
      #1;
      check_eq({tag, "_rst_phase"}, 64'(phase), 64'(0));
      check_eq({tag, "_rst_busy"}, 64'(busy), 64'(0));
      check_eq({tag, "_rst_start"}, 64'(core_start), 64'(0));
      check_eq({tag, "_rst_key"}, core_key, 64'(0));
      check_eq({tag, "_rst_data"}, core_data, 64'(0));
      check_eq({tag, "_rst_dec"}, 64'(core_decrypt), 64'(0));
      check_eq({tag, "_rst_disp"}, 64'(disp), 64'(0));
      check_eq({tag, "_rst_idx"}, 64'(word_idx), 64'(0));
      @(posedge clk); #1;
      rst = 1'b1;
      model_reset();
      restarted = 1'b0;
      core_done = 1'b1;
      core_result = 64'hDEAD_BEEF_DEAD_BEEF;
      repeat (20) begin
        @(negedge clk);
        if (core_start || phase != 3'd0) restarted = 1'b1;
      end
      core_done = 1'b0;
      check_eq({tag, "_post_rst_quiet"}, 64'(restarted), 64'(0));
      check_idle({tag, "_post_rst"});
      return;
    end
    @(posedge clk); #1;
    send_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_n = 1'b1;
    repeat (dly) @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_still_wait"}, 64'(phase), 64'(5));
    check_eq({tag, "_wait_disp"}, 64'(disp), 64'(0));
    r = {$urandom, $urandom};
    @(posedge clk); #1;
    core_done = 1'b1;
    core_result = r;
    m_result = r;
    @(posedge clk); #1;
    core_done = 1'b0;
    core_result = {$urandom, $urandom};
    @(negedge clk);
    check_eq({tag, "_res_phase"}, 64'(phase), 64'(6));
    m_phase = 6;
    select_disp = SEL_W'($urandom);
    @(posedge clk);
    check_idle({tag, "_res"});
  endtask

  task automatic act_go(input int dly, input string tag);
    if (m_phase == 3 || (m_phase == 6 && Chain)) do_run(dly, 1'b0, tag);
    else press(1'b0, 1'b0, 1'b1, 1, tag);
  endtask

  initial begin
    logic [IN_W-1:0] vals[4];
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333; vals[3] = 16'h4444;
    model_reset();
    #12;
    check_eq("reset_phase", 64'(phase), 64'(0));
    check_eq("reset_start", 64'(core_start), 64'(0));
    check_eq("reset_busy", 64'(busy), 64'(0));
    check_eq("reset_disp", 64'(disp), 64'(0));
    check_eq("reset_dec", 64'(core_decrypt), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    check_idle("reset");

    select_disp = 2'd3;
    for (int i = 0; i < 4; i++) begin
      user_input = vals[i];
      press(1'b1, 1'b0, 1'b0, 2, "key_entry");
    end
    check_eq("key_show_disp", 64'(disp), 64'h4444);
    check_eq("key_show_key", core_key, 64'h4444_3333_2222_1111);

    press(1'b0, 1'b1, 1'b0, 1, "back_to_key");
    press(1'b0, 1'b1, 1'b0, 1, "back_idx2");
    press(1'b0, 1'b1, 1'b0, 1, "back_idx1");
    user_input = 16'hAAAA;
    press(1'b1, 1'b0, 1'b0, 1, "reenter");
    check_eq("reenter_key", core_key, 64'h4444_3333_AAAA_1111);
    user_input = 16'h5555;
    press(1'b1, 1'b0, 1'b0, 50, "held_send");
    check_eq("held_key", core_key, 64'h4444_5555_AAAA_1111);
    user_input = 16'h6666;
    press(1'b1, 1'b1, 1'b0, 1, "send_back");
    check_eq("send_back_key", core_key, 64'h6666_5555_AAAA_1111);

    press(1'b1, 1'b0, 1'b0, 1, "to_data");
    for (int i = 0; i < 4; i++) begin
      user_input = 16'($urandom);
      press(1'b1, 1'b0, 1'b0, 1, "data_entry");
    end
    do_run(20, 1'b0, "first_run");
    select_disp = 2'd0;
    @(negedge clk);
    @(negedge clk);
    act_go(5, "result_go");

    press(1'b1, 1'b0, 1'b0, 1, "again_data");
    for (int i = 0; i < 4; i++) begin
      user_input = 16'($urandom);
      press(1'b1, 1'b0, 1'b0, 1, "again_entry");
    end
    do_run(5, 1'b1, "abort");

    for (int n = 0; n < 150; n++) begin
      int sel;
      user_input = 16'($urandom);
      select_disp = SEL_W'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel < 5)      press(1'b1, 1'b0, 1'b0, int'($urandom_range(1, 4)), "rnd_send");
      else if (sel < 8) press(1'b0, 1'b1, 1'b0, int'($urandom_range(1, 4)), "rnd_back");
      else              act_go(int'($urandom_range(1, 25)), "rnd_go");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
